// File: rtl/rs_berl_ibm.sv
// rs_berl_ibm: inversionless Berlekamp-Massey key-equation solver (Lambda, L, fail).
// Define RS_BERL_IBM_OMEGA_EN to also compute the error evaluator Omega(x) in T extra cycles.
module rs_berl_ibm #(
  parameter int unsigned T    = 8,
  parameter int unsigned M    = 8,
  parameter logic [M:0]  POLY = 9'h11D,
  parameter int unsigned LW   = $clog2(2*T+1)
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*T*M-1:0]     syndromes,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [(T+1)*M-1:0]   lambda,
  output logic [T*M-1:0]       omega,
  output logic [LW-1:0]        err_len,
  output logic                 fail
);

  localparam int unsigned PW = 2*M - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISC,
    S_UPD,
    S_DONE
`ifdef RS_BERL_IBM_OMEGA_EN
    , S_OMEGA
`endif
  } state_t;

  // Carry-less M x M product followed by reduction modulo POLY.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < int'(M); i++)
      if (b[i]) p = p ^ (PW'(a) << i);
    for (int k = int'(PW) - 1; k >= int'(M); k--)
      if (p[k]) p = p ^ (PW'(POLY) << (k - int'(M)));
    return p[M-1:0];
  endfunction

  state_t        state_q, state_d;
  logic [M-1:0]  synd_q  [2*T];
  logic [M-1:0]  synd_d  [2*T];
  logic [M-1:0]  lam_q   [T+1];
  logic [M-1:0]  lam_d   [T+1];
  logic [M-1:0]  b_q     [T+1];
  logic [M-1:0]  b_d     [T+1];
  logic [M-1:0]  gamma_q, gamma_d;
  logic [M-1:0]  delta_q, delta_d;
  logic [LW-1:0] l_q, l_d;
  logic [LW-1:0] r_q, r_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          fail_q, fail_d;
  logic [M-1:0]  disc_c;
`ifdef RS_BERL_IBM_OMEGA_EN
  logic [M-1:0]  om_q [T];
  logic [M-1:0]  om_d [T];
`endif

  // Shared T+1 multiply lanes: sum of Lambda_j * S_(r-j); r_q doubles as the Omega index.
  always_comb begin
    logic [M-1:0] sel;
    disc_c = '0;
    for (int j = 0; j <= int'(T); j++) begin
      sel = '0;
      for (int k = 0; k < int'(2*T); k++)
        if (int'(r_q) - j == k) sel = synd_q[k];
      disc_c = disc_c ^ gf_mul(lam_q[j], sel);
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    logic          fin;
    logic [LW-1:0] deg;
    fin     = 1'b0;
    deg     = '0;
    state_d = state_q;
    synd_d  = synd_q;
    lam_d   = lam_q;
    b_d     = b_q;
    gamma_d = gamma_q;
    delta_d = delta_q;
    l_d     = l_q;
    r_d     = r_q;
    fail_d  = fail_q;
`ifdef RS_BERL_IBM_OMEGA_EN
    om_d    = om_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          for (int k = 0; k < int'(2*T); k++) synd_d[k] = syndromes[k*M +: M];
          lam_d    = '{default: '0};
          lam_d[0] = M'(1);
          b_d      = '{default: '0};
          b_d[0]   = M'(1);
          gamma_d  = M'(1);
          delta_d  = '0;
          l_d      = '0;
          r_d      = '0;
          state_d  = S_DISC;
        end
      end
      S_DISC: begin
        delta_d = disc_c;
        state_d = S_UPD;
      end
      S_UPD: begin
        lam_d[0] = gf_mul(gamma_q, lam_q[0]);
        for (int j = 1; j <= int'(T); j++)
          lam_d[j] = gf_mul(gamma_q, lam_q[j]) ^ gf_mul(delta_q, b_q[j-1]);
        if ((delta_q != '0) && ({l_q, 1'b0} <= {1'b0, r_q})) begin
          b_d     = lam_q;
          l_d     = r_q + LW'(1) - l_q;
          gamma_d = delta_q;
        end else begin
          b_d[0] = '0;
          for (int j = 1; j <= int'(T); j++) b_d[j] = b_q[j-1];
        end
        r_d     = r_q + LW'(1);
        state_d = S_DISC;
        if (r_q == LW'(2*T-1)) begin
`ifdef RS_BERL_IBM_OMEGA_EN
          r_d     = '0;
          state_d = S_OMEGA;
`else
          state_d = S_DONE;
          fin     = 1'b1;
`endif
        end
      end
`ifdef RS_BERL_IBM_OMEGA_EN
      S_OMEGA: begin
        for (int i = 0; i < int'(T); i++)
          if (int'(r_q) == i) om_d[i] = disc_c;
        r_d = r_q + LW'(1);
        if (r_q == LW'(T-1)) begin
          state_d = S_DONE;
          fin     = 1'b1;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Flag an uncorrectable pattern from the final Lambda as DONE is entered.
    if (fin) begin
      for (int j = 0; j <= int'(T); j++)
        if (lam_d[j] != '0) deg = LW'(j);
      fail_d = (l_d > LW'(T)) || (deg != l_d);
    end

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= S_IDLE;
      synd_q      <= '{default: '0};
      lam_q       <= '{default: '0};
      b_q         <= '{default: '0};
      gamma_q     <= '0;
      delta_q     <= '0;
      l_q         <= '0;
      r_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fail_q      <= 1'b0;
`ifdef RS_BERL_IBM_OMEGA_EN
      om_q        <= '{default: '0};
`endif
    end else begin
      state_q     <= state_d;
      synd_q      <= synd_d;
      lam_q       <= lam_d;
      b_q         <= b_d;
      gamma_q     <= gamma_d;
      delta_q     <= delta_d;
      l_q         <= l_d;
      r_q         <= r_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fail_q      <= fail_d;
`ifdef RS_BERL_IBM_OMEGA_EN
      om_q        <= om_d;
`endif
    end
  end

  always_comb begin
    lambda = '0;
    for (int j = 0; j <= int'(T); j++) lambda[j*M +: M] = lam_q[j];
  end

`ifdef RS_BERL_IBM_OMEGA_EN
  always_comb begin
    omega = '0;
    for (int i = 0; i < int'(T); i++) omega[i*M +: M] = om_q[i];
  end
`else
  assign omega = '0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign err_len   = l_q;
  assign fail      = fail_q;

endmodule

// File: tb/tb_rs_berl_ibm.sv
// Scoreboard bench for rs_berl_ibm: fixed patterns, error-derived and random syndromes,
// back-pressure and mid-run reset. Follows RS_BERL_IBM_OMEGA_EN for latency and Omega.
module tb_rs_berl_ibm;

  localparam int unsigned T    = 8;
  localparam int unsigned M    = 8;
  localparam int unsigned LW   = $clog2(2*T+1);
  localparam int unsigned SW   = 2*T*M;
  localparam int unsigned LAMW = (T+1)*M;
  localparam int unsigned OMW  = T*M;
  localparam int unsigned CW   = 256;
  localparam logic [M:0]  POLY = 9'h11D;
`ifdef RS_BERL_IBM_OMEGA_EN
  localparam int LAT = 5*T;
  localparam bit OM  = 1'b1;
`else
  localparam int LAT = 4*T;
  localparam bit OM  = 1'b0;
`endif

  typedef struct packed {
    logic [LAMW-1:0] lam;
    logic [OMW-1:0]  om;
    logic [LW-1:0]   len;
    logic            fl;
  } res_t;

  logic            clk = 1'b0;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   syndromes;
  logic            out_valid;
  logic            out_ready;
  logic [LAMW-1:0] lambda;
  logic [OMW-1:0]  omega;
  logic [LW-1:0]   err_len;
  logic            fail;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  rs_berl_ibm #(.T(T), .M(M), .POLY(POLY), .LW(LW)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .syndromes(syndromes), .out_valid(out_valid), .out_ready(out_ready),
    .lambda(lambda), .omega(omega), .err_len(err_len), .fail(fail)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Shift-and-add GF(2^M) multiply, reducing a on every step.
  function automatic logic [M-1:0] m_mul(input logic [M-1:0] a_in, input logic [M-1:0] b);
    logic [M-1:0] a, r;
    a = a_in;
    r = '0;
    for (int i = 0; i < int'(M); i++) begin
      if (b[i]) r = r ^ a;
      a = a[M-1] ? ((a << 1) ^ POLY[M-1:0]) : (a << 1);
    end
    return r;
  endfunction

  function automatic logic [M-1:0] m_pow(input int e);
    logic [M-1:0] a;
    a = M'(1);
    for (int n = 0; n < e % 255; n++) a = m_mul(a, M'(2));
    return a;
  endfunction

  function automatic res_t model(input logic [SW-1:0] s);
    logic [M-1:0] sy[2*T];
    logic [M-1:0] lam[T+1];
    logic [M-1:0] b[T+1];
    logic [M-1:0] nl[T+1];
    logic [M-1:0] gam, del, acc;
    int l, deg;
    res_t r;
    for (int i = 0; i < int'(2*T); i++) sy[i] = s[i*M +: M];
    for (int j = 0; j <= int'(T); j++) begin lam[j] = '0; b[j] = '0; end
    lam[0] = M'(1);
    b[0]   = M'(1);
    gam    = M'(1);
    l      = 0;
    for (int k = 0; k < int'(2*T); k++) begin
      del = '0;
      for (int j = 0; j <= int'(T); j++)
        if (k - j >= 0) del = del ^ m_mul(lam[j], sy[k-j]);
      for (int j = 0; j <= int'(T); j++)
        nl[j] = m_mul(gam, lam[j]) ^ ((j > 0) ? m_mul(del, b[j-1]) : M'(0));
      if (del != '0 && 2*l <= k) begin
        b   = lam;
        l   = k + 1 - l;
        gam = del;
      end else begin
        for (int j = int'(T); j > 0; j--) b[j] = b[j-1];
        b[0] = '0;
      end
      lam = nl;
    end
    r = '0;
    deg = 0;
    for (int j = 0; j <= int'(T); j++) begin
      r.lam[j*M +: M] = lam[j];
      if (lam[j] != '0) deg = j;
    end
    if (OM) begin
      for (int i = 0; i < int'(T); i++) begin
        acc = '0;
        for (int j = 0; j <= i; j++) acc = acc ^ m_mul(lam[j], sy[i-j]);
        r.om[i*M +: M] = acc;
      end
    end
    r.len = LW'(l);
    r.fl  = (l > int'(T)) || (deg != l);
    return r;
  endfunction

  // Syndromes of nerr errors at distinct positions: S_i = sum e_k * alpha^(i*p_k).
  function automatic logic [SW-1:0] err_synd(input int nerr, input int start);
    logic [SW-1:0] s;
    logic [M-1:0]  acc, ev;
    int p;
    s = '0;
    for (int i = 0; i < int'(2*T); i++) begin
      acc = '0;
      for (int k = 0; k < nerr; k++) begin
        p   = (start + k*7) % 255;
        ev  = M'(1 + ((start*13 + k*29) % 255));
        acc = acc ^ m_mul(ev, m_pow(p*i));
      end
      s[i*M +: M] = acc;
    end
    return s;
  endfunction

  function automatic res_t mk(input logic [LAMW-1:0] lam, input logic [OMW-1:0] om,
                              input logic [LW-1:0] len, input logic fl);
    res_t r;
    r.lam = lam;
    r.om  = OM ? om : '0;
    r.len = len;
    r.fl  = fl;
    return r;
  endfunction

  // Present syndromes and wait for acceptance; returns 1 ns after the accepting edge.
  task automatic send(input logic [SW-1:0] s, input res_t e, input bit push);
    int guard;
    guard     = 0;
    in_valid  = 1'b1;
    syndromes = s;
    while (!in_ready && guard < 4*LAT) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_ready", CW'(in_ready), CW'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  // Wait for a result, compare with the scoreboard head, optionally hold it, then accept.
  task automatic collect(input int lat, input int exp_len, input int hold);
    res_t e;
    int n;
    n = 0;
    while (!out_valid && n < 4*LAT) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", CW'(n), CW'(lat));
    check("sb_depth", CW'(exp_q.size()), CW'(1));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("out_valid", CW'(out_valid), CW'(1));
    check("lambda", CW'(lambda), CW'(e.lam));
    check("omega", CW'(omega), CW'(e.om));
    check("err_len", CW'(err_len), CW'(e.len));
    check("fail", CW'(fail), CW'(e.fl));
    if (exp_len >= 0) begin
      check("err_len_vs_errors", CW'(err_len), CW'(exp_len));
      check("fail_correctable", CW'(fail), CW'(0));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("bp_valid", CW'(out_valid), CW'(1));
      check("bp_ready", CW'(in_ready), CW'(0));
      check("bp_lambda", CW'(lambda), CW'(e.lam));
      check("bp_omega", CW'(omega), CW'(e.om));
      check("bp_len", CW'(err_len), CW'(e.len));
      check("bp_fail", CW'(fail), CW'(e.fl));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", CW'(out_valid), CW'(0));
    check("release_ready", CW'(in_ready), CW'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, CW'(in_ready), CW'(1));
    check({tag, "_out_valid"}, CW'(out_valid), CW'(0));
    check({tag, "_lambda"}, CW'(lambda), CW'(0));
    check({tag, "_omega"}, CW'(omega), CW'(0));
    check({tag, "_err_len"}, CW'(err_len), CW'(0));
    check({tag, "_fail"}, CW'(fail), CW'(0));
  endtask

  initial begin
    logic [SW-1:0] s, s2;
    int nerr;
    clr       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    syndromes = '0;
    repeat (3) @(posedge clk);
    #1 clr = 1'b0;
    check_reset_values("reset");

    // All-zero syndromes: no errors.
    s = '0;
    send(s, mk(LAMW'(1), OMW'(0), LW'(0), 1'b0), 1'b1);
    collect(LAT, -1, 0);

    // All S_i = 1: single error at position 0, Lambda = 1 + x.
    for (int i = 0; i < int'(2*T); i++) s[i*M +: M] = M'(1);
    send(s, mk(LAMW'(16'h0101), OMW'(1), LW'(1), 1'b0), 1'b1);
    collect(LAT, -1, 0);

    // Only S_0 set: inconsistent, Lambda collapses to 1 while L = 1.
    s = '0;
    s[M-1:0] = M'(1);
    send(s, mk(LAMW'(1), OMW'(1), LW'(1), 1'b1), 1'b1);
    collect(LAT, -1, 0);

    // Back-pressure with a second word waiting on the bus.
    s  = err_synd(3, 40);
    s2 = err_synd(2, 100);
    send(s, model(s), 1'b1);
    in_valid  = 1'b1;
    syndromes = s2;
    collect(LAT, 3, 10);
    @(posedge clk); #1;
    check("bp_accept_after_release", CW'(in_ready), CW'(0));
    in_valid = 1'b0;
    exp_q.push_back(model(s2));
    collect(LAT, 2, 0);

    // Reset in the middle of a single-error run; the partial result never appears.
    for (int i = 0; i < int'(2*T); i++) s[i*M +: M] = M'(1);
    send(s, model(s), 1'b0);
    repeat (9) begin @(posedge clk); #1; end
    @(posedge clk);
    #1 clr = 1'b1;
    #1 check_reset_values("midreset");
    @(posedge clk);
    #1 clr = 1'b0;
    check("midreset_released_valid", CW'(out_valid), CW'(0));
    s = '0;
    send(s, mk(LAMW'(1), OMW'(0), LW'(0), 1'b0), 1'b1);
    collect(LAT, -1, 0);

    // Correctable error patterns of random weight.
    for (int t = 0; t < 4; t++) begin
      nerr = 1 + int'($urandom_range(T-1, 0));
      s = err_synd(nerr, int'($urandom_range(254, 0)));
      send(s, model(s), 1'b1);
      collect(LAT, nerr, 0);
    end

    // Arbitrary syndromes, typically uncorrectable.
    for (int t = 0; t < 3; t++) begin
      for (int w = 0; w < int'(SW/32); w++) s[w*32 +: 32] = $urandom();
      send(s, model(s), 1'b1);
      collect(LAT, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs_berl_ibm.md
# rs_berl_ibm

Parametrised inversionless Berlekamp–Massey (iBM) key-equation solver for the Reed–Solomon decoder. It sits between the syndrome calculator and the Chien/Forney stage. The block accepts 2T syndromes through a valid/ready handshake and iterates 2T times, using T+1 parallel GF(2^M) multiply lanes. It then returns the error-locator polynomial Λ(x), its register length L, a failure flag and, optionally, the error-evaluator Ω(x), through a second handshake.

## Interface
- T, default 8: correction capability. The block takes 2T syndromes. Range 1..16.
- M, default 8: symbol width in bits, GF(2^M).
- POLY, default 9'h11D: field primitive polynomial, width M+1. Bit M is always 1.
- LW, default $clog2(2*T+1): width of L.

- clk, in, 1: clock. All state updates on the rising edge.
- clr, in, 1: reset, asynchronous, active-high.
- in_valid, in, 1: syndrome bus valid.
- in_ready, out, 1: block can accept syndromes. High only in IDLE.
- syndromes, in, 2T*M: S_i at bits [i*M +: M], i = 0..2T-1.
- out_valid, out, 1: results valid. Held until accepted.
- out_ready, in, 1: downstream accepts results.
- lambda, out, (T+1)*M: Λ_j at bits [j*M +: M].
- omega, out, T*M: Ω_i at bits [i*M +: M].
- err_len, out, LW: final L.
- fail, out, 1: uncorrectable pattern detected.

## Operation
- State machine: IDLE → DISC ↔ UPD (2T iterations) → OMEGA (T cycles, if enabled) → DONE → IDLE.
- IDLE: in_ready = 1.
  - On in_valid & in_ready, register the syndromes and initialise: Λ = 1, B = 1, γ = 1, L = 0, r = 0. Go to DISC.
- DISC: compute δ = Σ_{j=0..T} Λ_j·S_{r−j}, with S_k = 0 for k < 0, and register it. Go to UPD.
- UPD:
  - Λ ← γ·Λ − δ·x·B. The x·B term truncates at degree T.
  - If δ ≠ 0 and 2L ≤ r, then B ← old Λ, L ← r+1−L, γ ← δ. Otherwise B ← x·B, with B_T dropped.
  - r ← r+1. If r reaches 2T, go to OMEGA (or DONE when that stage is compiled out); else go to DISC.
- OMEGA: over cycle i = 0..T−1, Ω_i ← Σ_{j=0..i} Λ_j·S_{i−j}. The DISC multiplier lanes are reused. Then go to DONE.
- DONE:
  - out_valid = 1; lambda, omega, err_len and fail are stable.
  - On out_ready, go to IDLE. out_valid drops, and in_ready rises the following cycle.
- fail = (L > T) or (deg Λ ≠ L), evaluated in DONE.
- Λ is not monic; it is scaled by the product of γ values. Chien roots are unaffected. Ω is computed from the same Λ, so the Forney ratio is unaffected.
- Arithmetic:
  - GF add is XOR; subtraction equals addition.
  - The multiplier is a generic M×M carry-less product reduced by POLY. It must be bit-identical to the existing GF(2^8) multiplier for the defaults.
- Syndromes arriving while not in IDLE are ignored (in_ready = 0).

## Timing
- Reset values: in_ready = 1 (IDLE), out_valid = 0, lambda = 0, omega = 0, err_len = 0, fail = 0. All internal registers are 0 and state is IDLE.
- Acceptance edge e0. Edges e1..e4T perform the 2T DISC/UPD pairs.
- out_valid is visible after edge e4T without Ω. With Ω it is visible after edge e5T.
- The acceptance latency is independent of syndrome content; there is no early exit.
- Back-pressure: out_valid, lambda, omega, err_len and fail hold while out_ready = 0.
- Throughput: one codeword per 4T+2 cycles (5T+2 with Ω) when out_ready is held high.
- clr asserted mid-operation: immediate return to reset values. The partial result is discarded and never presented.

## Configuration
- RS_BERL_IBM_OMEGA_EN defined:
  - OMEGA state and omega port logic are present.
  - Latency is 5T edges.
- RS_BERL_IBM_OMEGA_EN undefined:
  - OMEGA state is removed and omega is tied to 0.
  - UPD goes straight to DONE; latency is 4T edges.

## Test plan
- Reset: assert clr for 3 cycles, release. Expect in_ready = 1, out_valid = 0, all outputs 0.
- Zero syndromes, T = 8, all S_i = 0. Expect after e32 (e40 with Ω): lambda = 1, err_len = 0, fail = 0, omega = 0.
- Single error, T = 8, all S_i = 8'h01. Expect Λ = 1 + x (Λ_0 = Λ_1 = 8'h01, other coefficients 0), err_len = 1, fail = 0, Ω_0 = 8'h01 with Ω_1..Ω_7 = 0.
- Inconsistent pattern, T = 8, S_0 = 8'h01 and all other S_i = 0. Expect Λ = 1, err_len = 1, fail = 1 (deg Λ ≠ L).
- Back-pressure: hold out_ready = 0 for 10 cycles after out_valid rises, while driving in_valid = 1. Expect outputs stable, in_ready = 0, and no new acceptance until one cycle after out_ready.
- Reset mid-operation: pulse clr at e10 of a single-error run. Expect reset values immediately. A following zero-syndrome input must complete with the correct result.
